// File: rtl/sid_spi_writer_pkg.sv
// Shared SID write-path definitions: field widths, the FSM state type and the
// two-byte write encoding also used by the receive-side decoder.
package sid_spi_writer_pkg;

    localparam int SID_ADDR_W = 5;
    localparam int SID_DATA_W = 8;
    localparam int REQ_W      = SID_ADDR_W + SID_DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // First byte carries the write marker, the address and the top two data bits.
    function automatic logic [7:0] sid_enc_byte0(input logic [SID_ADDR_W-1:0] addr,
                                                 input logic [SID_DATA_W-1:0] data);
        return {1'b1, addr, data[7:6]};
    endfunction

    function automatic logic [7:0] sid_enc_byte1(input logic [SID_DATA_W-1:0] data);
        return {2'b00, data[5:0]};
    endfunction

endpackage

// File: rtl/sid_spi_writer_if.sv
// Request handshake plus SPI pin bundle of the SID SPI writer.
interface sid_spi_writer_if #(
    parameter int FIFO_DEPTH = 4
);
    import sid_spi_writer_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  iValid;
    logic                  oReady;
    logic [SID_ADDR_W-1:0] iAddr;
    logic [SID_DATA_W-1:0] iData;
    logic                  oSck;
    logic                  oMosi;
    logic                  oCsN;
    logic                  oBusy;
    logic [LVL_W-1:0]      oLevel;

    modport master (
        output iValid, iAddr, iData,
        input  oReady, oSck, oMosi, oCsN, oBusy, oLevel
    );

    modport slave (
        input  iValid, iAddr, iData,
        output oReady, oSck, oMosi, oCsN, oBusy, oLevel
    );

endinterface

// File: rtl/sid_req_fifo.sv
// Synchronous request FIFO with registered occupancy; read data is the head
// entry, valid whenever the FIFO is non-empty.
module sid_req_fifo
    import sid_spi_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = REQ_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (!do_push && do_pop) level_q <= level_q - 1'b1;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sid_spi_writer.sv
// SPI mode-0 master that sends each queued SID write as two CS-framed bytes.
//  state | meaning
//  IDLE  | no transfer, waiting for a FIFO entry
//  SHIFT | CS low, shifting 8 bits MSB first (low phase then high phase)
//  HOLD  | CS low, SCK low for one half-period after bit 0
//  GAP   | CS high between bytes; next byte or next request follows directly
module sid_spi_writer
    import sid_spi_writer_pkg::*;
#(
    parameter int CLK_DIV    = 6,
    parameter int CS_GAP     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    sid_spi_writer_if.slave   bus
);
    localparam int         LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    spi_state_e       state_q;
    logic [7:0]       cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic [7:0]       byte1_q;
    logic             byte_idx_q;
    logic             sck_q;
    logic             mosi_q;
    logic             csn_q;

    logic [REQ_W-1:0] req;
    logic [LVL_W-1:0] level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [7:0]       req_b0;
    logic [7:0]       req_b1;

    assign push   = bus.iValid && !fifo_full;
    assign pop    = !fifo_empty &&
                    ((state_q == IDLE) || (state_q == GAP && cnt_q == '0 && byte_idx_q));
    assign req_b0 = sid_enc_byte0(req[REQ_W-1 -: SID_ADDR_W], req[SID_DATA_W-1:0]);
    assign req_b1 = sid_enc_byte1(req[SID_DATA_W-1:0]);

    sid_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({bus.iAddr, bus.iData}),
        .pop_i   (pop),
        .rdata_o (req),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            byte1_q    <= '0;
            byte_idx_q <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            csn_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q <= DIV_LAST;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q == '0) begin
                                state_q <= HOLD;
                            end else begin
                                bit_q  <= bit_q - 1'b1;
                                mosi_q <= sh_q[7];
                                sh_q   <= {sh_q[6:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= GAP;
                        csn_q   <= 1'b1;
                        mosi_q  <= 1'b0;
                        cnt_q   <= GAP_LAST;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!byte_idx_q) begin
                        state_q    <= SHIFT;
                        byte_idx_q <= 1'b1;
                        csn_q      <= 1'b0;
                        mosi_q     <= byte1_q[7];
                        sh_q       <= {byte1_q[6:0], 1'b0};
                        bit_q      <= 3'd7;
                        cnt_q      <= DIV_LAST;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A pop starts the next request from IDLE or straight out of the second GAP.
            if (pop) begin
                state_q    <= SHIFT;
                byte1_q    <= req_b1;
                byte_idx_q <= 1'b0;
                csn_q      <= 1'b0;
                mosi_q     <= req_b0[7];
                sh_q       <= {req_b0[6:0], 1'b0};
                bit_q      <= 3'd7;
                cnt_q      <= DIV_LAST;
            end
        end
    end

    assign bus.oSck   = sck_q;
    assign bus.oMosi  = mosi_q;
    assign bus.oCsN   = csn_q;
    assign bus.oLevel = level;
    assign bus.oReady = (level != LVL_W'(FIFO_DEPTH));
    assign bus.oBusy  = (state_q != IDLE) || (level != '0);

endmodule

// File: tb/tb_sid_spi_writer.sv
// Scoreboard bench for sid_spi_writer at default timing and at the fastest legal timing.
module tb_sid_spi_writer;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sid_spi_writer_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
    sid_spi_writer_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

    sid_spi_writer #(.CLK_DIV(6), .CS_GAP(12), .FIFO_DEPTH(DEPTH)) u0 (
        .clk (clk), .rst (rst), .bus (bus0));
    sid_spi_writer #(.CLK_DIV(3), .CS_GAP(1), .FIFO_DEPTH(DEPTH)) u1 (
        .clk (clk), .rst (rst), .bus (bus1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int div_of(input int k);
        return (k == 0) ? 6 : 3;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? 12 : 1;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic sck_w [2];
    logic csn_w [2];
    logic mosi_w[2];
    assign sck_w[0]  = bus0.oSck;
    assign sck_w[1]  = bus1.oSck;
    assign csn_w[0]  = bus0.oCsN;
    assign csn_w[1]  = bus1.oCsN;
    assign mosi_w[0] = bus0.oMosi;
    assign mosi_w[1] = bus1.oMosi;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    logic       sck_p[2];
    logic       csn_p[2];
    logic [7:0] sr[2];
    int         nbits[2];
    int         bidx[2];
    int         fall_c[2];
    int         rise_c[2];
    int         sck_rises[2] = '{0, 0};
    bit         burst_mode[2] = '{1'b0, 1'b0};
    bit         prev_v[2] = '{1'b0, 1'b0};
    int         prev_start[2];

    // Receiver model: sample MOSI on each SCK rise, close a byte on each CS_N rise.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!burst_mode[k]) prev_v[k] = 1'b0;
            if (rst) begin
                nbits[k] = 0;
                bidx[k]  = 0;
                sr[k]    = '0;
            end else begin
                if (sck_w[k] && !sck_p[k]) begin
                    sck_rises[k]++;
                    sr[k] = {sr[k][6:0], mosi_w[k]};
                    nbits[k]++;
                end
                if (!csn_w[k] && csn_p[k]) begin
                    fall_c[k] = cyc;
                    if (bidx[k] == 1) begin
                        chk("pair_gap", cyc - rise_c[k], gap_of(k));
                    end else if (burst_mode[k]) begin
                        if (prev_v[k])
                            chk("req_spacing", cyc - prev_start[k], 2 * (17 * div_of(k) + gap_of(k)));
                        prev_v[k]     = 1'b1;
                        prev_start[k] = cyc;
                    end
                end
                if (csn_w[k] && !csn_p[k]) begin
                    logic [7:0] e;
                    int         qs;
                    rise_c[k] = cyc;
                    chk("cs_low_len", cyc - fall_c[k], 17 * div_of(k));
                    chk("bit_count", nbits[k], 8);
                    qs = (k == 0) ? exp0.size() : exp1.size();
                    chk("byte_expected", (qs > 0), 1);
                    if (qs > 0) begin
                        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk("byte", sr[k], e);
                    end
                    nbits[k] = 0;
                    bidx[k]  = 1 - bidx[k];
                end
            end
            sck_p[k] = sck_w[k];
            csn_p[k] = csn_w[k];
        end
    end

    int  v_cyc;
    bit  seen_full;

    task automatic send(input int k, input logic [4:0] a, input logic [7:0] d, input bit check_rdy);
        int   budget;
        logic rdy;
        logic [2:0] lvl;
        budget = 0;
        @(negedge clk);
        v_cyc = cyc;
        if (k == 0) begin
            bus0.iValid = 1'b1; bus0.iAddr = a; bus0.iData = d;
        end else begin
            bus1.iValid = 1'b1; bus1.iAddr = a; bus1.iData = d;
        end
        forever begin
            rdy = (k == 0) ? bus0.oReady : bus1.oReady;
            lvl = (k == 0) ? bus0.oLevel : bus1.oLevel;
            if (check_rdy) begin
                chk("ready_vs_level", rdy, (lvl != 3'(DEPTH)));
                if (lvl == 3'(DEPTH)) seen_full = 1'b1;
            end
            @(posedge clk);
            if (rdy) break;
            budget++;
            if (budget > 2000) begin
                chk("send_timeout", 1, 0);
                break;
            end
            @(negedge clk);
        end
        if (k == 0) begin
            exp0.push_back({1'b1, a, d[7:6]});
            exp0.push_back({2'b00, d[5:0]});
        end else begin
            exp1.push_back({1'b1, a, d[7:6]});
            exp1.push_back({2'b00, d[5:0]});
        end
    endtask

    task automatic drop_valid(input int k);
        @(negedge clk);
        if (k == 0) bus0.iValid = 1'b0;
        else        bus1.iValid = 1'b0;
    endtask

    task automatic wait_idle(input int k, output int at);
        int budget;
        budget = 0;
        at = 0;
        forever begin
            @(negedge clk);
            if (((k == 0) ? bus0.oBusy : bus1.oBusy) == 1'b0 &&
                ((k == 0) ? exp0.size() : exp1.size()) == 0) begin
                at = cyc;
                break;
            end
            budget++;
            if (budget > 20000) begin
                chk("idle_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic single_write(input int k, input logic [4:0] a, input logic [7:0] d);
        int budget;
        int at;
        send(k, a, d, 1'b0);
        drop_valid(k);
        budget = 0;
        forever begin
            @(negedge clk);
            if (((k == 0) ? bus0.oCsN : bus1.oCsN) == 1'b0) break;
            budget++;
            if (budget > 50) begin
                chk("csn_fall_timeout", 1, 0);
                break;
            end
        end
        chk("push_to_csn", cyc - v_cyc, 2);
        wait_idle(k, at);
    endtask

    initial begin
        int at;
        int budget;
        int rises;

        bus0.iValid = 1'b0; bus0.iAddr = '0; bus0.iData = '0;
        bus1.iValid = 1'b0; bus1.iAddr = '0; bus1.iData = '0;

        repeat (3) @(negedge clk);
        chk("rst_csn",   bus0.oCsN,   1);
        chk("rst_sck",   bus0.oSck,   0);
        chk("rst_mosi",  bus0.oMosi,  0);
        chk("rst_level", bus0.oLevel, 0);
        chk("rst_ready", bus0.oReady, 1);
        chk("rst_busy",  bus0.oBusy,  0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        single_write(0, 5'h18, 8'h0F);
        single_write(0, 5'h1F, 8'hFF);
        single_write(0, 5'h00, 8'h00);

        // Burst of 8 with iValid held high.
        seen_full     = 1'b0;
        burst_mode[0] = 1'b1;
        for (int i = 0; i < 8; i++) send(0, 5'($urandom), 8'($urandom), 1'b1);
        drop_valid(0);
        wait_idle(0, at);
        chk("busy_fall", at - rise_c[0], 12);
        chk("burst_saw_full", seen_full, 1);
        burst_mode[0] = 1'b0;

        // Reset during bit 3 of the second byte with two entries still queued.
        for (int i = 0; i < 3; i++) send(0, 5'($urandom), 8'($urandom), 1'b0);
        drop_valid(0);
        budget = 0;
        forever begin
            @(negedge clk);
            if (bidx[0] == 1 && nbits[0] == 4 && bus0.oCsN == 1'b0) break;
            budget++;
            if (budget > 2000) begin
                chk("bit3_timeout", 1, 0);
                break;
            end
        end
        repeat (7) @(negedge clk);
        chk("pre_rst_level", bus0.oLevel, 2);
        chk("pre_rst_sck",   bus0.oSck,   0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_csn",   bus0.oCsN,   1);
        chk("mid_rst_sck",   bus0.oSck,   0);
        chk("mid_rst_mosi",  bus0.oMosi,  0);
        chk("mid_rst_level", bus0.oLevel, 0);
        chk("mid_rst_ready", bus0.oReady, 1);
        chk("mid_rst_busy",  bus0.oBusy,  0);
        exp0.delete();
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        rises = sck_rises[0];
        repeat (300) @(negedge clk);
        chk("post_rst_no_sck", sck_rises[0], rises);
        chk("post_rst_csn",    bus0.oCsN,    1);

        // Fastest legal timing on the second instance.
        single_write(1, 5'h18, 8'h0F);
        single_write(1, 5'h1F, 8'hFF);
        burst_mode[1] = 1'b1;
        for (int i = 0; i < 6; i++) send(1, 5'($urandom), 8'($urandom), 1'b1);
        drop_valid(1);
        wait_idle(1, at);
        chk("fast_busy_fall", at - rise_c[1], 1);
        burst_mode[1] = 1'b0;

        // 25 random writes decoded by the receiver model.
        for (int i = 0; i < 25; i++) send(0, 5'($urandom), 8'($urandom), 1'b1);
        drop_valid(0);
        wait_idle(0, at);

        chk("exp0_drained", exp0.size(), 0);
        chk("exp1_drained", exp1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sid_spi_writer.md
# sid_spi_writer

- Host-side SPI master that serialises SID register writes into the two-byte write format accepted by the SID core's SPI receive path.
- Accepts (address, data) write requests over a valid/ready handshake and buffers them in a small FIFO.
- Emits each request as two SPI mode-0 bytes.
- Sits on the driver/player FPGA, or in loopback test builds, where it drives the PM4 SPI bus of a SID board.

## Interface
Parameters:
- CLK_DIV, 6: clk cycles per SCK half-period (12 MHz clk gives 1 MHz SCK); legal range 1..255.
- CS_GAP, 12: clk cycles CS_N is held high between bytes; legal range 1..255.
- FIFO_DEPTH, 4: request FIFO entries; power of two, at least 2.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, 12 MHz
- rst  in  1  asynchronous active-high reset
- iValid  in  1  write request valid
- oReady  out  1  FIFO can accept a request
- iAddr  in  5  SID register address
- iData  in  8  SID register data
- oSck  out  1  SPI clock, idles low
- oMosi  out  1  SPI data, MSB first
- oCsN  out  1  SPI chip select, active low
- oBusy  out  1  FIFO non-empty or transfer in progress
- oLevel  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
Request handling:
- A request is pushed when iValid && oReady on a rising edge of clk.
- oReady = (oLevel != FIFO_DEPTH).
- Simultaneous push and pop is allowed at any level except full. When full, a pop in that cycle does not raise oReady until the next cycle.

Byte encoding:
- First byte: {1'b1, addr[4:0], data[7:6]}.
- Second byte: {2'b00, data[5:0]}. The bit 6 don't-care position is always sent as 0.

Transfer FSM, one transfer per request:
- IDLE: when the FIFO is non-empty, pop the entry, latch both bytes, set byte index = 0, go to SHIFT.
- SHIFT: oCsN = 0. For each of bits 7..0:
  - Low phase of CLK_DIV cycles: oSck = 0, oMosi = current bit, set at the start of the phase.
  - High phase of CLK_DIV cycles: oSck = 1, oMosi stable.
- HOLD: after bit 0's high phase, oSck = 0 and oCsN = 0 for CLK_DIV cycles.
- GAP: oCsN = 1, oMosi = 0 for CS_GAP cycles.
  - If byte index = 0, set it to 1 and go to SHIFT.
  - Otherwise go to IDLE.
- The two bytes of a request are never interleaved with another request. The first byte of the next request follows the GAP directly with no IDLE dwell cycle.
- oBusy = (state != IDLE) || (oLevel != 0).

Reset (asserted at any time, including mid-byte or mid-pair):
- oCsN = 1, oSck = 0, oMosi = 0, state = IDLE, FIFO flushed, oLevel = 0, oReady = 1, oBusy = 0.
- A partial byte is abandoned. The receiver discards it because CS_N rises.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Push to first CS_N fall: 2 cycles when idle (one cycle FIFO write, one cycle IDLE pop).
- Per byte: CS_N is low for 17*CLK_DIV cycles, then high for CS_GAP cycles.
- Per request: 2*(17*CLK_DIV + CS_GAP) cycles. With defaults that is 228 cycles (19 us), below the SID's register-write needs.
- Rising SCK edges occur CLK_DIV cycles after each MOSI change, giving a setup of CLK_DIV clk cycles.
- The SCK rate and CS_N gap must give the receiver's clk-domain synchroniser at least 3 clk cycles per SCK level. This holds for CLK_DIV >= 3 when both ends run at 12 MHz.

## Structure
- Shared package constants:
  - SID_ADDR_W = 5 and SID_DATA_W = 8.
  - The encode functions for the first and second bytes, shared with the receive decoder for consistency.
  - The FSM state enum: IDLE, SHIFT, HOLD, GAP.
- One sub-module: sid_req_fifo, a synchronous FIFO 13 bits wide and FIFO_DEPTH deep with level output and async reset.
- Bit and phase counters are 3-bit and 8-bit, kept inline in the FSM.

## Test plan
- Single write, addr 0x18, data 0x0F: sampling MOSI on SCK rise gives 0xE0 then 0x0F; CS_N is low for 102 cycles per byte, with a 12-cycle gap.
- Write addr 0x1F, data 0xFF gives 0xFF then 0x3F. Write addr 0x00, data 0x00 gives 0x80 then 0x00.
- Back-to-back burst of 8 requests with iValid held high:
  - oReady drops whenever oLevel = 4.
  - All 16 bytes arrive in order with none lost.
  - Consecutive requests are 228 cycles apart.
  - oBusy falls 1 cycle after the final GAP.
- Reset mid-byte, asserted during bit 3 of the second byte with 2 entries queued: CS_N high, SCK low, oLevel = 0, oReady = 1 immediately; no further SCK edges.
- Loopback with the SPI receiver and SID register decoder: 25 random (addr, data) writes produce the matching busWE/busAddr/busDataW pulses on the receiving side.
- CLK_DIV = 3, CS_GAP = 1: correct bytes at the maximum legal rate; per-request time is 104 cycles.
